// File: rtl/lc3_sequencer.sv
// LC-3 control sequencer: fetch/decode/execute FSM driving datapath loads, bus gates, muxes and SRAM strobes.
// Define ISDU_PAUSE_IR_EN to add the IRP1/IRP2 instruction-register pause after every fetch.
module lc3_sequencer #(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic       ContinueIR,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_CE_n,
    output logic       Mem_UB_n,
    output logic       Mem_LB_n,
    output logic       Mem_OE_n,
    output logic       Mem_WE_n,
    output logic       Busy
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
        S04, S21, S06, S25, S27, S07, S23, S16, PAUSE1, PAUSE2
`ifdef ISDU_PAUSE_IR_EN
        , IRP1, IRP2
`endif
    } state_t;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic [1:0] drmux;
        logic [1:0] sr1mux;
        logic       sr2_sel;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mio_en;
        logic       mem_oe_n;
        logic       mem_we_n;
        logic       busy;
    } ctl_t;

    // Wait counter holds the number of strobe cycles still to follow the current one.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    ctl_t       ctl;

    function automatic ctl_t decode(input state_t s, input logic [3:0] c);
        ctl_t o;
        o          = '0;
        o.mem_oe_n = 1'b1;
        o.mem_we_n = 1'b1;
        o.busy     = (s != HALTED);
        case (s)
            S18: begin
                o.gate_pc = 1'b1;
                o.ld_mar  = 1'b1;
                o.ld_pc   = 1'b1;
            end
            S33, S25: begin
                o.mem_oe_n = 1'b0;
                o.mio_en   = 1'b1;
                o.ld_mdr   = (c == 4'd0);
            end
            S35: begin
                o.gate_mdr = 1'b1;
                o.ld_ir    = 1'b1;
            end
            S32: o.ld_ben = 1'b1;
            S01, S05, S09: begin
                o.gate_alu = 1'b1;
                o.ld_reg   = 1'b1;
                o.ld_cc    = 1'b1;
                o.sr2_sel  = 1'b1;
                o.aluk     = (s == S01) ? 2'b00 : (s == S05) ? 2'b01 : 2'b10;
            end
            S22: begin
                o.ld_pc    = 1'b1;
                o.pcmux    = 2'b01;
                o.addr2mux = 2'b10;
            end
            S12: begin
                o.ld_pc    = 1'b1;
                o.pcmux    = 2'b01;
                o.addr1mux = 1'b1;
            end
            S04: begin
                o.gate_pc = 1'b1;
                o.ld_reg  = 1'b1;
                o.drmux   = 2'b01;
            end
            S21: begin
                o.ld_pc    = 1'b1;
                o.pcmux    = 2'b01;
                o.addr2mux = 2'b11;
            end
            S06, S07: begin
                o.gate_marmux = 1'b1;
                o.ld_mar      = 1'b1;
                o.addr1mux    = 1'b1;
                o.addr2mux    = 2'b01;
            end
            S27: begin
                o.gate_mdr = 1'b1;
                o.ld_reg   = 1'b1;
                o.ld_cc    = 1'b1;
            end
            S23: begin
                o.sr1mux   = 2'b01;
                o.aluk     = 2'b11;
                o.gate_alu = 1'b1;
                o.ld_mdr   = 1'b1;
            end
            S16: o.mem_we_n = 1'b0;
            default: ;
        endcase
        return o;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            HALTED: if (Run) state_nxt = S18;
            S18: begin
                state_nxt = S33;
                cnt_nxt   = WAIT_LOAD;
            end
            S33: begin
                if (cnt == 4'd0) state_nxt = S35;
                else             cnt_nxt   = cnt - 4'd1;
            end
`ifdef ISDU_PAUSE_IR_EN
            S35:  state_nxt = IRP1;
            IRP1: if (ContinueIR)  state_nxt = IRP2;
            IRP2: if (!ContinueIR) state_nxt = S32;
`else
            S35:  state_nxt = S32;
`endif
            S32: begin
                case (Opcode)
                    4'b0001: state_nxt = S01;
                    4'b0101: state_nxt = S05;
                    4'b1001: state_nxt = S09;
                    4'b0000: state_nxt = S00;
                    4'b1100: state_nxt = S12;
                    4'b0100: state_nxt = S04;
                    4'b0110: state_nxt = S06;
                    4'b0111: state_nxt = S07;
                    4'b1101: state_nxt = PAUSE1;
                    default: state_nxt = S18;
                endcase
            end
            S01, S05, S09, S22, S12, S21, S27: state_nxt = S18;
            S00: state_nxt = BEN ? S22 : S18;
            S04: state_nxt = S21;
            S06: begin
                state_nxt = S25;
                cnt_nxt   = WAIT_LOAD;
            end
            S25: begin
                if (cnt == 4'd0) state_nxt = S27;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S07: state_nxt = S23;
            S23: begin
                state_nxt = S16;
                cnt_nxt   = WAIT_LOAD;
            end
            S16: begin
                if (cnt == 4'd0) state_nxt = S18;
                else             cnt_nxt   = cnt - 4'd1;
            end
            PAUSE1: if (Continue)  state_nxt = PAUSE2;
            PAUSE2: if (!Continue) state_nxt = S18;
            default: state_nxt = HALTED;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= HALTED;
            cnt   <= 4'd0;
            ctl   <= decode(HALTED, 4'd0);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ctl   <= decode(state_nxt, cnt_nxt);
        end
    end

`ifndef ISDU_PAUSE_IR_EN
    logic unused_continue_ir;
    assign unused_continue_ir = ContinueIR;
`endif

    assign LD_MAR     = ctl.ld_mar;
    assign LD_MDR     = ctl.ld_mdr;
    assign LD_IR      = ctl.ld_ir;
    assign LD_BEN     = ctl.ld_ben;
    assign LD_CC      = ctl.ld_cc;
    assign LD_REG     = ctl.ld_reg;
    assign LD_PC      = ctl.ld_pc;
    assign GatePC     = ctl.gate_pc;
    assign GateMDR    = ctl.gate_mdr;
    assign GateALU    = ctl.gate_alu;
    assign GateMARMUX = ctl.gate_marmux;
    assign PCMUX      = ctl.pcmux;
    assign DRMUX      = ctl.drmux;
    assign SR1MUX     = ctl.sr1mux;
    // SR2MUX follows the live IR bit during the ALU states.
    assign SR2MUX     = ctl.sr2_sel & IR_5;
    assign ADDR1MUX   = ctl.addr1mux;
    assign ADDR2MUX   = ctl.addr2mux;
    assign ALUK       = ctl.aluk;
    assign MIO_EN     = ctl.mio_en;
    assign Mem_OE_n   = ctl.mem_oe_n;
    assign Mem_WE_n   = ctl.mem_we_n;
    assign Busy       = ctl.busy;
    assign Mem_CE_n   = 1'b0;
    assign Mem_UB_n   = 1'b0;
    assign Mem_LB_n   = 1'b0;

endmodule
